// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures high/low segment widths of din in clk cycles and queues {level, width} records.
// Define PW_GLITCH_FILTER_EN to require the synchronized level to persist 2 cycles before it is accepted.
module pulse_width_meter #(
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          din,
    input  logic                          enable,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_level,
    output logic [CNT_W-1:0]              out_width,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef PW_GLITCH_FILTER_EN
    localparam int WARM = 4;
`else
    localparam int WARM = 3;
`endif

    typedef enum logic [1:0] {IDLE, ARMING, MEASURE} state_t;

    state_t            state, state_nxt;
    logic              s1, s2, lvl, lvl_d, edge_det;
    logic [WARM-1:0]   warm;
    logic [CNT_W-1:0]  cnt;
    logic              push_r;
    logic [CNT_W:0]    rec_r;
    logic [CNT_W:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              full, pop, wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl_d <= 1'b0;
            warm  <= '0;
        end else begin
            s1    <= din;
            s2    <= s1;
            lvl_d <= lvl;
            warm  <= {warm[WARM-2:0], 1'b1};
        end
    end

`ifdef PW_GLITCH_FILTER_EN
    logic s3, filt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3   <= 1'b0;
            filt <= 1'b0;
        end else begin
            s3   <= s2;
            filt <= lvl;
        end
    end
    assign lvl = (s2 == s3) ? s2 : filt;
`else
    assign lvl = s2;
`endif

    // Edges are ignored until the pipeline has refilled after reset, so reset release is never an edge.
    assign edge_det = warm[WARM-1] && (lvl != lvl_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = !enable ? IDLE :
                    (state == IDLE) ? ARMING :
                    (state == ARMING && edge_det) ? MEASURE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            push_r <= 1'b0;
            rec_r  <= '0;
        end else begin
            cnt    <= (state == IDLE) ? '0 : edge_det ? CNT_W'(1) : (&cnt) ? cnt : cnt + 1'b1;
            push_r <= enable && (state == MEASURE) && edge_det;
            rec_r  <= {lvl_d, cnt};
        end
    end

    assign full      = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign out_valid = fifo_count != '0;
    assign pop       = out_valid && out_ready;
    assign wr        = push_r && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(wr) - (AW+1)'(pop);
            overflow   <= (push_r && full && !pop) ? 1'b1 : clr_ovf ? 1'b0 : overflow;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= rec_r;
    end

    assign {out_level, out_width} = out_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter: segment-level reference model feeds an expected-record queue; a forked monitor checks every pop.
module tb_pulse_width_meter;
    localparam int CNT_W = 8;
    localparam int DEPTH = 8;
    localparam int MAXW  = (1 << CNT_W) - 1;

    logic clk = 0, rst_n = 0, din = 0, enable = 0, out_ready = 0, clr_ovf = 0;
    logic out_valid, out_level, overflow;
    logic [CNT_W-1:0] out_width;
    logic [$clog2(DEPTH):0] fifo_count;

    int vectors = 0, errors = 0;
    logic [CNT_W:0] q[$];
    int pushed = 0, popped = 0, cur_len = 0;
    bit rand_ready = 0, drop_ok = 0, exp_ovf = 0, cur_level = 0, armed = 0;

    always #5 clk = ~clk;

    pulse_width_meter #(.CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .enable(enable),
        .out_valid(out_valid), .out_ready(out_ready), .out_level(out_level),
        .out_width(out_width), .fifo_count(fifo_count), .overflow(overflow),
        .clr_ovf(clr_ovf)
    );

    task automatic check(string name, int act, int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cur_len++;
        if (rand_ready) out_ready = ($urandom % 2) == 1;
    endtask

    // A level change closes the current segment; it becomes a record only once armed by an earlier change.
    task automatic flip(bit l);
        logic [CNT_W:0] r;
        if (l != cur_level) begin
            if (enable && armed) begin
                if (drop_ok && pushed - popped >= DEPTH) exp_ovf = 1;
                else begin
                    r = {cur_level, CNT_W'(cur_len > MAXW ? MAXW : cur_len)};
                    q.push_back(r);
                    pushed++;
                end
            end
            armed = enable;
            cur_level = l;
            cur_len = 0;
        end
        din = l;
    endtask

    task automatic seg(bit l, int len);
        flip(l);
        repeat (len) tick();
    endtask

    task automatic pattern();
        seg(1, 20); seg(0, 30); seg(1, 40); seg(0, 50); seg(1, 60); seg(0, 100);
    endtask

    task automatic set_enable(bit e);
        enable = e;
        armed = 0;
    endtask

    task automatic drain();
        rand_ready = 0;
        out_ready = 1;
        for (int i = 0; i < 300 && (q.size() != 0 || fifo_count != 0); i++) tick();
        check("drain_queue", q.size(), 0);
        check("drain_count", fifo_count, 0);
    endtask

    task automatic monitor();
        logic [CNT_W:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("valid_vs_count", out_valid, fifo_count != 0);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) check("pop_when_model_empty", out_valid, 0);
                    else begin
                        e = q.pop_front();
                        check("rec_level", out_level, e[CNT_W]);
                        check("rec_width", out_width, e[CNT_W-1:0]);
                    end
                    popped++;
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        repeat (3) tick();
        check("rst_valid", out_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_width", out_width, 0);
        check("rst_level", out_level, 0);
        rst_n = 1;
        cur_len = 0;
        set_enable(1);
        repeat (6) tick();

        out_ready = 1;
        pattern(); pattern();
        drain();

        out_ready = 0;
        drop_ok = 1;
        exp_ovf = 0;
        pattern(); pattern();
        check("hold_count", fifo_count, DEPTH);
        check("hold_ovf", overflow, exp_ovf);
        clr_ovf = 1; tick(); clr_ovf = 0; tick();
        check("ovf_cleared", overflow, 0);
        drop_ok = 0;
        drain();

        out_ready = 0;
        while (pushed - popped < DEPTH) seg(!cur_level, 10);
        check("full_before", fifo_count, DEPTH);
        flip(!cur_level);
        repeat (3) tick();
        out_ready = 1;
        tick();
        out_ready = 0;
        check("full_pushpop_count", fifo_count, DEPTH);
        check("full_pushpop_ovf", overflow, 0);
        repeat (10) tick();
        drain();

        rand_ready = 1;
        for (int i = 0; i < 60; i++) seg(!cur_level, $urandom_range(40, 6));
        repeat (10) tick();
        drain();

        out_ready = 1;
        seg(1, 30); seg(0, 1); seg(1, 30); seg(0, 20);
        drain();

        seg(!cur_level, 300); seg(!cur_level, 20);
        drain();

        out_ready = 0;
        repeat (3) seg(!cur_level, 15);
        set_enable(0);
        repeat (3) seg(!cur_level, 15);
        check("idle_count", fifo_count, pushed - popped);
        drain();
        set_enable(1);
        repeat (3) seg(!cur_level, 15);
        drain();

        out_ready = 0;
        seg(!cur_level, 20); seg(!cur_level, 20);
        flip(1);
        repeat (30) tick();
        rst_n = 0;
        tick();
        check("midrst_valid", out_valid, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_ovf", overflow, 0);
        check("midrst_width", out_width, 0);
        check("midrst_level", out_level, 0);
        q.delete();
        pushed = 0;
        popped = 0;
        tick();
        rst_n = 1;
        armed = 0;
        cur_len = 0;
        out_ready = 1;
        repeat (10) tick();
        seg(0, 25); seg(1, 35); seg(0, 20);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/pulse_width_meter.md
PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

Interface
REQ-001 Parameter CNT_W, default 16, width of the measured-width field in clock cycles.
REQ-002 Parameter FIFO_DEPTH, default 8, number of record slots; power of two, at least 2.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 din  input  1  asynchronous test-pattern waveform being measured.
REQ-006 enable  input  1  measurement enable; low = idle.
REQ-007 out_valid  output  1  a record is present at the FIFO head.
REQ-008 out_ready  input  1  consumer accepts the head record.
REQ-009 out_level  output  1  din level of the reported segment.
REQ-010 out_width  output  CNT_W  duration of the reported segment in clk cycles.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored records.
REQ-012 overflow  output  1  sticky flag: a record was dropped.
REQ-013 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-014 din SHALL pass through a 2-flop synchronizer; its output is lvl.
REQ-015 An edge SHALL be flagged in any cycle where lvl differs from its value in the previous cycle.
REQ-016 The counter SHALL load 1 on an edge and otherwise increment, saturating at 2^CNT_W-1; a level held N cycles yields width N (N < 2^CNT_W).
REQ-017 On each edge while enable=1 and armed=1, the block SHALL push {previous level, counter} into the FIFO.
REQ-018 States: IDLE (enable=0), ARMING (enabled, no edge yet), MEASURE; IDLE->ARMING on enable=1; ARMING->MEASURE on first edge, with no push; any state->IDLE on enable=0.
REQ-019 In IDLE the counter SHALL hold 0, no pushes SHALL occur, and FIFO contents SHALL remain poppable.
REQ-020 The first, partial segment after enable rises or reset is released SHALL be discarded.
REQ-021 Latency: din edge to out_valid rising (FIFO empty) SHALL be 4 clk cycles: 2 sync + 1 edge + 1 write.
REQ-022 out_valid SHALL equal (fifo_count != 0); out_level/out_width SHALL show the head record and hold stable while out_valid=1 and out_ready=0.
REQ-023 A pop SHALL occur on a clk edge where out_valid=1 and out_ready=1.
REQ-024 A push with FIFO full and no pop SHALL be dropped and set overflow; stored records are unchanged.
REQ-025 A push and pop in the same cycle SHALL both succeed even when full; fifo_count is unchanged.
REQ-026 out_ready while empty SHALL have no effect.
REQ-027 overflow SHALL clear on clr_ovf=1; a drop in the same cycle wins (overflow stays 1).
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH with no lost or duplicated records.

Reset
REQ-029 While rst_n=0: synchronizer flops, counter, pointers, fifo_count, out_valid and overflow SHALL be 0, and the state SHALL be IDLE.
REQ-030 out_level and out_width SHALL read 0 during reset.
REQ-031 Reset asserted mid-segment SHALL discard all stored and in-progress data; after release, REQ-020 applies.

Configuration
REQ-032 With macro PW_GLITCH_FILTER_EN defined, lvl SHALL update only after the synchronized din holds a new value for 2 consecutive cycles; 1-cycle pulses are ignored and latency becomes 5 cycles.
REQ-033 Without PW_GLITCH_FILTER_EN, lvl SHALL be the raw synchronizer output, as specified in REQ-014 to REQ-021.

Verification
REQ-034 Test-pattern waveform at clk=1 MHz, 300-cycle period, edges at 0/20/50/90/140/200, enable=1, out_ready=1 -> records (after the first discard) are H20, L30, H40, L50, H60, L100, repeating.
REQ-035 Same pattern with out_ready=0 -> exactly 8 records stored, fifo_count=8, the 9th edge sets overflow, and subsequent pops return the first 8 records in order.
REQ-036 Pulse/edge drives a push at full and out_ready=1 in the same cycle -> no drop, fifo_count stays 8, overflow stays 0.
REQ-037 din held high 70000 cycles with CNT_W=16 -> width reported as 65535.
REQ-038 rst_n pulsed low at cycle 100 of the pattern -> all outputs 0, and the next valid record is the first complete segment after the following edge.
REQ-039 1-cycle glitch on din: with PW_GLITCH_FILTER_EN -> no extra records; without it -> two extra records, one of width 1.
